// File: rtl/uart_receiver.sv
// ============================================================================
// Module   : uart_receiver
// Purpose  : 8N1 UART receive stage; oversamples rx, holds one byte for the CPU
//            and reports valid, framing-error and overrun status.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_receiver #(
    parameter int CLKS_PER_BIT = 52,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 read_ack,
    input  logic                 clear_errors,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 framing_error,
    output logic                 overrun,
    output logic                 busy
);

    localparam int               CNT_W      = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] c_HALF_M1  = CNT_W'(CLKS_PER_BIT/2 - 1);
    localparam logic [CNT_W-1:0] c_BIT_M1   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       c_LAST_IDX = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_sync1;
    logic                  r_rx_s;
    logic [CNT_W-1:0]      r_cnt;
    logic [2:0]            r_bit_idx;
    logic [DATA_BITS-1:0]  r_shift;
    logic [DATA_BITS-1:0]  r_data;
    logic                  r_valid;
    logic                  r_ferr;
    logic                  r_ovr;
    logic                  w_tick;
    logic                  w_half;
    logic                  w_load;
    logic                  w_bad_stop;

    assign w_tick     = (r_cnt == c_BIT_M1);
    assign w_half     = (r_cnt == c_HALF_M1);
    assign w_load     = (r_state == S_STOP) && w_tick && r_rx_s;
    assign w_bad_stop = (r_state == S_STOP) && w_tick && !r_rx_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
            r_state <= S_IDLE;
        end else begin
            r_sync1 <= rx;
            r_rx_s  <= r_sync1;
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (!r_rx_s) w_state_next = S_START;
            // Mid-start recheck rejects glitches shorter than half a bit
            S_START: if (w_half) w_state_next = r_rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (w_tick && (r_bit_idx == c_LAST_IDX)) w_state_next = S_STOP;
            S_STOP:  if (w_tick) w_state_next = r_rx_s ? S_IDLE : S_BREAK;
            S_BREAK: if (r_rx_s) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= '0;
        end else begin
            if ((w_state_next != r_state) || ((r_state == S_DATA) && w_tick)) begin
                r_cnt <= '0;
            end else if ((r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if ((r_state == S_START) && (w_state_next == S_DATA)) begin
                r_bit_idx <= 3'd0;
            end else if ((r_state == S_DATA) && w_tick && (r_bit_idx != c_LAST_IDX)) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end

            if ((r_state == S_DATA) && w_tick) begin
                r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
            end
        end
    end

    // A byte load takes priority over a coincident read_ack or clear_errors
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (w_load) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (read_ack) begin
                r_valid <= 1'b0;
            end

            if (w_load && r_valid && !read_ack) begin
                r_ovr <= 1'b1;
            end else if (clear_errors) begin
                r_ovr <= 1'b0;
            end

            if (w_bad_stop) begin
                r_ferr <= 1'b1;
            end else if (clear_errors) begin
                r_ferr <= 1'b0;
            end
        end
    end

    assign data_out      = r_data;
    assign data_valid    = r_valid;
    assign framing_error = r_ferr;
    assign overrun       = r_ovr;
    assign busy          = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_receiver.sv
// ============================================================================
// Module   : tb_uart_receiver
// Purpose  : Self-checking bench for uart_receiver (directed table + random).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_receiver;

    localparam int CPB     = 52;
    localparam int FRAME   = 10 * CPB;
    localparam int LOAD_LAT = 2 + CPB/2 + 9*CPB;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       read_ack;
    logic       clear_errors;
    logic [7:0] data_out;
    logic       data_valid;
    logic       framing_error;
    logic       overrun;
    logic       busy;

    always #5 clk = ~clk;

    uart_receiver #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .rx            (rx),
        .read_ack      (read_ack),
        .clear_errors  (clear_errors),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .framing_error (framing_error),
        .overrun       (overrun),
        .busy          (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] m_data;
    logic       m_dv, m_fe, m_ov;

    typedef struct {
        logic       send;
        logic [7:0] b;
        logic       stop;
        logic       ack_load;
        int         post;
        logic [7:0] e_data;
        logic       e_dv;
        logic       e_fe;
        logic       e_ov;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".data"}, 32'(data_out), 32'(m_data));
        chk({tag, ".valid"}, 32'(data_valid), 32'(m_dv));
        chk({tag, ".ferr"}, 32'(framing_error), 32'(m_fe));
        chk({tag, ".ovr"}, 32'(overrun), 32'(m_ov));
    endtask

    // Drives one frame bit-by-bit; lat = edges after the first low sample until data_valid rose
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic ack_load,
                              output int lat);
        logic [9:0] bits;
        logic       prev;
        bits = {stop, b, 1'b0};
        lat  = -1;
        prev = data_valid;
        rx   = bits[0];
        for (int k = 1; k <= FRAME; k++) begin
            @(posedge clk);
            #1;
            if (lat < 0 && !prev && data_valid) lat = k - 1;
            prev     = data_valid;
            read_ack = ack_load && (k == LOAD_LAT);
            if (k < FRAME) rx = bits[k / CPB];
        end
        read_ack = 1'b0;
    endtask

    // Reference model: what the CPU should observe after one frame
    task automatic model_frame(input logic [7:0] b, input logic stop, input logic ack);
        if (stop) begin
            if (m_dv && !ack) m_ov = 1'b1;
            m_data = b;
            m_dv   = 1'b1;
        end else begin
            m_fe = 1'b1;
            if (ack) m_dv = 1'b0;
        end
    endtask

    task automatic apply_post(input int p);
        if (p == 1) begin
            read_ack = 1'b1;
            step(1);
            read_ack = 1'b0;
            m_dv = 1'b0;
        end else if (p == 2) begin
            clear_errors = 1'b1;
            step(1);
            clear_errors = 1'b0;
            m_fe = 1'b0;
            m_ov = 1'b0;
        end
    endtask

    task automatic release_break(input int hold);
        step(hold);
        chk("break.busy_held", 32'(busy), 32'd1);
        rx = 1'b1;
        step(1);
        chk("break.busy_sync", 32'(busy), 32'd1);
        step(3);
        chk("break.busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int         lat;
        logic [9:0] bits;
        logic [7:0] rb;
        logic       rs, ra;
        int         rp;

        tbl[0] = '{1'b1, 8'h48, 1'b1, 1'b0, 0, 8'h48, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 8'h48, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 8'h55, 1'b1, 1'b0, 0, 8'h55, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 8'hA3, 1'b1, 1'b0, 0, 8'hA3, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 8'hA3, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 8'hA3, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 8'h3C, 1'b0, 1'b0, 0, 8'hA3, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{1'b1, 8'h01, 1'b1, 1'b0, 0, 8'h01, 1'b1, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 8'h01, 1'b1, 1'b0, 1'b0};
        tbl[9] = '{1'b1, 8'h7E, 1'b1, 1'b1, 0, 8'h7E, 1'b1, 1'b0, 1'b0};

        reset = 1'b1; rx = 1'b1; read_ack = 1'b0; clear_errors = 1'b0;
        m_data = 8'h00; m_dv = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
        step(3);
        chk("reset.data", 32'(data_out), 32'h0);
        chk("reset.valid", 32'(data_valid), 32'h0);
        chk("reset.ferr", 32'(framing_error), 32'h0);
        chk("reset.ovr", 32'(overrun), 32'h0);
        chk("reset.busy", 32'(busy), 32'h0);
        reset = 1'b0;
        step(4);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].send) begin
                send_frame(tbl[i].b, tbl[i].stop, tbl[i].ack_load, lat);
                model_frame(tbl[i].b, tbl[i].stop, tbl[i].ack_load);
                if (i == 0) chk("latency", 32'(lat), 32'd496);
                if (!tbl[i].stop) begin
                    release_break(200);
                end
            end
            apply_post(tbl[i].post);
            rx = 1'b1;
            step(4);
            chk($sformatf("tbl%0d.data", i), 32'(data_out), 32'(tbl[i].e_data));
            chk($sformatf("tbl%0d.valid", i), 32'(data_valid), 32'(tbl[i].e_dv));
            chk($sformatf("tbl%0d.ferr", i), 32'(framing_error), 32'(tbl[i].e_fe));
            chk($sformatf("tbl%0d.ovr", i), 32'(overrun), 32'(tbl[i].e_ov));
            chk($sformatf("tbl%0d.busy", i), 32'(busy), 32'd0);
        end

        // Short low glitch must be rejected at the mid-start check
        rx = 1'b0;
        step(10);
        chk("glitch.busy_start", 32'(busy), 32'd1);
        rx = 1'b1;
        step(25);
        chk("glitch.busy_idle", 32'(busy), 32'd0);
        chk_model("glitch");

        // Reset in the middle of data bit 4 of 0xFF
        bits = {1'b1, 8'hFF, 1'b0};
        rx = bits[0];
        for (int k = 1; k <= 5*CPB + CPB/2; k++) begin
            step(1);
            rx = bits[k / CPB];
        end
        chk("rst_mid.busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_mid.async_valid", 32'(data_valid), 32'd0);
        step(1);
        chk("rst_mid.data", 32'(data_out), 32'h0);
        chk("rst_mid.valid", 32'(data_valid), 32'h0);
        chk("rst_mid.ferr", 32'(framing_error), 32'h0);
        chk("rst_mid.ovr", 32'(overrun), 32'h0);
        chk("rst_mid.busy", 32'(busy), 32'h0);
        rx = 1'b1;
        step(2);
        reset = 1'b0;
        m_data = 8'h00; m_dv = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
        step(4);
        send_frame(8'h81, 1'b1, 1'b0, lat);
        model_frame(8'h81, 1'b1, 1'b0);
        step(4);
        chk_model("after_rst");
        chk("after_rst.busy", 32'(busy), 32'd0);

        // Randomized frames against the reference model
        for (int i = 0; i < 40; i++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 7) != 0);
            ra = ($urandom_range(0, 3) == 0);
            send_frame(rb, rs, ra, lat);
            model_frame(rb, rs, ra);
            if (!rs) release_break($urandom_range(0, 100));
            rp = $urandom_range(0, 2);
            apply_post(rp);
            rx = 1'b1;
            step($urandom_range(4, 12));
            chk_model($sformatf("rnd%0d", i));
            chk($sformatf("rnd%0d.busy", i), 32'(busy), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receive stage for the 8-bit CPU's memory-mapped UART peripheral.
- Fills the DataIn slot (regSelect 2'b01) of the UART register block, alongside the existing transmitter.
- Oversamples the asynchronous rx pin with the system clock, frames 8N1 characters and holds one received byte for the CPU.
- Reports received-byte-valid, framing-error and overrun status.

Parameters:
- CLKS_PER_BIT, 52: system clocks per bit period; matches the transmitter bit time (2*(53/2)); must be even and ≥4.
- DATA_BITS, 8: data bits per frame, sent LSB first.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- rx  input  1  serial line from the pin, asynchronous, idles high
- read_ack  input  1  one-cycle pulse when the CPU reads DataIn; clears data_valid
- clear_errors  input  1  one-cycle pulse; clears framing_error and overrun
- data_out  output  DATA_BITS  last correctly framed byte
- data_valid  output  1  an unread byte is held in data_out
- framing_error  output  1  sticky; a stop bit was sampled low
- overrun  output  1  sticky; a byte arrived while data_valid was still set
- busy  output  1  state is not IDLE

Behaviour:
- Interface (decided): one clock, clk; reset is asynchronous and active-high, named reset.
- Reset values:
  - data_out=0, data_valid=0, framing_error=0, overrun=0, busy=0.
  - State=IDLE; bit counter=0; bit index=0.
  - Both synchronizer flops=1.
  - Reset mid-frame aborts the frame immediately; no partial byte is loaded.
- Synchronizer: two flops on rx produce rx_s. All logic uses rx_s only.
- Counters:
  - cnt is $clog2(CLKS_PER_BIT) bits wide and cleared on every state change.
  - bit_idx is 3 bits.
  - HALF = CLKS_PER_BIT/2.
- IDLE:
  - rx_s==0 → START; cnt=0.
- START:
  - cnt increments each clk.
  - When cnt==HALF-1: rx_s==0 → DATA (cnt=0, bit_idx=0); rx_s==1 → IDLE (glitch rejected, no flags change).
- DATA:
  - When cnt==CLKS_PER_BIT-1, shift rx_s into shift register MSB (LSB-first reception) and clear cnt.
  - bit_idx==DATA_BITS-1 → STOP; otherwise bit_idx+1.
- STOP: when cnt==CLKS_PER_BIT-1, sample rx_s.
  - rx_s==1 → load data_out from shift register, set data_valid, go IDLE.
    - If data_valid was 1 and read_ack is not asserted this cycle, also set overrun; the new byte still overwrites data_out.
  - rx_s==0 → set framing_error, leave data_out/data_valid unchanged, go BREAK.
- BREAK: wait until rx_s==1, then go IDLE. Prevents a held-low line (break) from re-triggering START.
- Latency:
  - data_valid rises on clock edge 2+HALF+9*CLKS_PER_BIT, counted after edge E0, the first edge at which the rx pin is sampled low.
  - With defaults this is edge 496.
- read_ack:
  - Clears data_valid on the next edge.
  - If it coincides with a byte load, the load wins: data_valid stays 1 and overrun is not set.
  - read_ack with data_valid=0 has no effect.
- clear_errors clears both sticky flags. If it coincides with a new error event, the error wins and the flag stays set.
- busy is combinational from state: 1 in START, DATA, STOP and BREAK.

Test Plan:
- Send 0x48 (8N1, 52 clk/bit) → data_valid rises on edge 496 after the first low sample, data_out=0x48, framing_error=0, busy=0 afterwards.
- 10-clock low glitch on idle rx → state returns to IDLE at the mid-start check; data_valid, framing_error and data_out unchanged.
- Send 0x55 then 0xA3 without read_ack → data_out=0xA3, data_valid=1, overrun=1. Then pulse clear_errors → overrun=0, data_valid still 1. Then pulse read_ack → data_valid=0.
- Send 0x3C with stop bit forced low, rx held low 200 clocks, then high → framing_error=1, data_out keeps its previous value, busy=1 until rx_s returns high, no second frame decoded. Then send 0x01 → data_out=0x01.
- read_ack pulsed on the exact edge a new byte 0x7E loads, with data_valid=1 → data_out=0x7E, data_valid=1, overrun=0.
- Assert reset during bit 4 of 0xFF → all outputs 0 next cycle. Deassert with rx idle high, then send 0x81 → data_out=0x81, no errors.
